// File: rtl/core_dbg_apb_bridge.sv
// core_dbg_apb_bridge
//   APB3/APB4 slave that forwards each APB transfer to the core debug register
//   interface as a req/ack transaction. PREADY stays low until the debug logic
//   acks or the wait times out. Misaligned or out-of-range accesses, and writes
//   with no strobes, complete locally with zero wait states.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_addr/i_sel/i_enable     APB PADDR/PSEL/PENABLE
//   i_wr_rd/i_wdata/i_wstrobe APB PWRITE/PWDATA/PSTRB
//   o_ready/o_rdata/o_slverr  APB PREADY/PRDATA/PSLVERR (registered)
//   o_dbg_*                   debug request channel, stable while o_dbg_req=1
//   i_dbg_ack/i_dbg_rdata/i_dbg_err  debug completion pulse with read data/error
module core_dbg_apb_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 5,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [APB_ADDR_WIDTH-1:0] i_addr,
  input  logic                      i_sel,
  input  logic                      i_enable,
  input  logic                      i_wr_rd,
  input  logic [APB_DATA_WIDTH-1:0] i_wdata,
  input  logic [3:0]                i_wstrobe,
  output logic                      o_ready,
  output logic [APB_DATA_WIDTH-1:0] o_rdata,
  output logic                      o_slverr,
  output logic                      o_dbg_req,
  output logic                      o_dbg_wr_rd,
  output logic [APB_ADDR_WIDTH-3:0] o_dbg_addr,
  output logic [APB_DATA_WIDTH-1:0] o_dbg_wdata,
  output logic [3:0]                o_dbg_wstrobe,
  input  logic                      i_dbg_ack,
  input  logic [APB_DATA_WIDTH-1:0] i_dbg_rdata,
  input  logic                      i_dbg_err
);

  localparam int unsigned IdxW = APB_ADDR_WIDTH - 2;
  // Keep at least one counter bit so TIMEOUT_CYCLES=0 still elaborates.
  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit              TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CntW-1:0] CntLast   = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax    = {CntW{1'b1}};

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e                    r_state, w_state_nxt;
  logic [CntW-1:0]           r_cnt, w_cnt_nxt;
  logic                      r_ready, w_ready_nxt;
  logic [APB_DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                      r_slverr, w_slverr_nxt;
  logic                      r_dbg_req, w_dbg_req_nxt;
  logic                      r_dbg_wr_rd, w_dbg_wr_rd_nxt;
  logic [IdxW-1:0]           r_dbg_addr, w_dbg_addr_nxt;
  logic [APB_DATA_WIDTH-1:0] r_dbg_wdata, w_dbg_wdata_nxt;
  logic [3:0]                r_dbg_wstrobe, w_dbg_wstrobe_nxt;

  logic [IdxW-1:0] w_idx;
  logic [31:0]     w_idx_ext;
  logic            w_bad;

  assign w_idx     = i_addr[APB_ADDR_WIDTH-1:2];
  assign w_idx_ext = 32'(w_idx);
  assign w_bad     = (|i_addr[1:0]) || (w_idx_ext >= NUM_REGS);

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_ready_nxt       = r_ready;
    w_rdata_nxt       = r_rdata;
    w_slverr_nxt      = r_slverr;
    w_dbg_req_nxt     = r_dbg_req;
    w_dbg_wr_rd_nxt   = r_dbg_wr_rd;
    w_dbg_addr_nxt    = r_dbg_addr;
    w_dbg_wdata_nxt   = r_dbg_wdata;
    w_dbg_wstrobe_nxt = r_dbg_wstrobe;

    unique case (r_state)
      StIdle: begin
        // Decode on the setup phase so local responses need no wait state.
        if (i_sel && !i_enable) begin
          if (w_bad) begin
            w_state_nxt  = StResp;
            w_ready_nxt  = 1'b1;
            w_slverr_nxt = 1'b1;
            w_rdata_nxt  = '0;
          end else if (i_wr_rd && (i_wstrobe == 4'h0)) begin
            w_state_nxt  = StResp;
            w_ready_nxt  = 1'b1;
            w_slverr_nxt = 1'b0;
            w_rdata_nxt  = '0;
          end else begin
            w_state_nxt       = StReq;
            w_cnt_nxt         = '0;
            w_dbg_req_nxt     = 1'b1;
            w_dbg_wr_rd_nxt   = i_wr_rd;
            w_dbg_addr_nxt    = w_idx;
            w_dbg_wdata_nxt   = i_wdata;
            w_dbg_wstrobe_nxt = i_wr_rd ? i_wstrobe : 4'hF;
          end
        end
      end
      StReq: begin
        if (!i_sel) begin
          // Master abandoned the transfer: withdraw the request, no response.
          w_state_nxt   = StIdle;
          w_dbg_req_nxt = 1'b0;
        end else if (i_dbg_ack) begin
          w_state_nxt   = StResp;
          w_dbg_req_nxt = 1'b0;
          w_ready_nxt   = 1'b1;
          w_slverr_nxt  = i_dbg_err;
          w_rdata_nxt   = r_dbg_wr_rd ? '0 : i_dbg_rdata;
        end else if (TimeoutEn && (r_cnt == CntLast)) begin
          w_state_nxt   = StResp;
          w_dbg_req_nxt = 1'b0;
          w_ready_nxt   = 1'b1;
          w_slverr_nxt  = 1'b1;
          w_rdata_nxt   = '0;
        end else if (r_cnt != CntMax) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StResp: begin
        w_state_nxt  = StIdle;
        w_ready_nxt  = 1'b0;
        w_slverr_nxt = 1'b0;
        w_rdata_nxt  = '0;
      end
      default: begin
        w_state_nxt   = StIdle;
        w_ready_nxt   = 1'b0;
        w_dbg_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_ready       <= 1'b0;
      r_rdata       <= '0;
      r_slverr      <= 1'b0;
      r_dbg_req     <= 1'b0;
      r_dbg_wr_rd   <= 1'b0;
      r_dbg_addr    <= '0;
      r_dbg_wdata   <= '0;
      r_dbg_wstrobe <= 4'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_ready       <= w_ready_nxt;
      r_rdata       <= w_rdata_nxt;
      r_slverr      <= w_slverr_nxt;
      r_dbg_req     <= w_dbg_req_nxt;
      r_dbg_wr_rd   <= w_dbg_wr_rd_nxt;
      r_dbg_addr    <= w_dbg_addr_nxt;
      r_dbg_wdata   <= w_dbg_wdata_nxt;
      r_dbg_wstrobe <= w_dbg_wstrobe_nxt;
    end
  end

  assign o_ready       = r_ready;
  assign o_rdata       = r_rdata;
  assign o_slverr      = r_slverr;
  assign o_dbg_req     = r_dbg_req;
  assign o_dbg_wr_rd   = r_dbg_wr_rd;
  assign o_dbg_addr    = r_dbg_addr;
  assign o_dbg_wdata   = r_dbg_wdata;
  assign o_dbg_wstrobe = r_dbg_wstrobe;

endmodule
